// File: rtl/climate_pkg.sv
// Shared encodings and reset defaults for the climate sequencer.
package climate_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_EVAL = 2'd3;

    localparam logic [1:0] CFG_ALARM_TH = 2'd0;
    localparam logic [1:0] CFG_FAN_TH   = 2'd1;
    localparam logic [1:0] CFG_HYST     = 2'd2;

    localparam logic [1:0] EST_OFF       = 2'd0;
    localparam logic [1:0] EST_MON       = 2'd1;
    localparam logic [1:0] EST_ALARM     = 2'd2;
    localparam logic [1:0] EST_ALARM_FAN = 2'd3;

    localparam int unsigned ALARM_TH_DEF = 30;
    localparam int unsigned FAN_TH_DEF   = 35;
    localparam int unsigned HYST_DEF     = 2;

endpackage

// File: rtl/persist_cnt.sv
// Saturating consecutive-hit counter; reached_o reflects the count being written this cycle.
module persist_cnt #(
    parameter int unsigned PERSIST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic set_i,
    input  logic step_i,
    input  logic hit_i,
    output logic reached_o
);

    localparam logic [3:0] CNT_MAX = 4'(PERSIST);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (set_i) begin
            cnt_d = CNT_MAX;
        end else if (step_i) begin
            if (!hit_i) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign reached_o = (cnt_d == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/climate_seq.sv
// Temperature alarm/fan sequencer: periodic sampling, persistence, hysteresis, fan min on-time.
// Optional SMP_TIMEOUT_EN adds a sample-ack timeout with fail-safe alarm and an smp_err port.
module climate_seq
    import climate_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned PERSIST    = 3,
    parameter int unsigned FAN_MIN_ON = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              smp_req,
    input  logic              smp_ack,
    input  logic [DATA_W-1:0] smp_data,
    output logic              en_alarma,
    output logic              en_ventilador,
    output logic [1:0]        estado,
    output logic              cfg_err
`ifdef SMP_TIMEOUT_EN
    ,
    output logic              smp_err
`endif
);

    localparam int unsigned    TW     = $clog2(SAMPLE_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(SAMPLE_DIV - 1);

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] alarm_th_q, alarm_th_d, fan_th_q, fan_th_d, hyst_q, hyst_d;
    logic              alarm_q, alarm_d, fan_q, fan_d;
    logic [3:0]        on_cnt_q, on_cnt_d, on_next;
    logic              smp_req_q, smp_req_d, cfg_err_q, cfg_err_d;
    logic [1:0]        estado_q, estado_d;

    logic              is_eval, a_hit, f_hit, a_reached, f_reached, tmo_hit;
    logic [DATA_W-1:0] alarm_lo, fan_lo;

    assign is_eval  = (state_q == ST_EVAL);
    assign alarm_lo = (alarm_th_q > hyst_q) ? alarm_th_q - hyst_q : '0;
    assign fan_lo   = (fan_th_q > hyst_q) ? fan_th_q - hyst_q : '0;
    assign a_hit    = (sample_q >= alarm_th_q);
    assign f_hit    = alarm_q && (sample_q >= fan_th_q);
    assign on_next  = (fan_q && on_cnt_q != 4'hf) ? on_cnt_q + 4'd1 : on_cnt_q;

`ifdef SMP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       smp_err_q, smp_err_d;

    assign tmo_hit = (state_q == ST_REQ) && !smp_ack && (tmo_q == TMO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    persist_cnt #(.PERSIST(PERSIST)) u_alarm_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!en),
        .set_i     (tmo_hit),
        .step_i    (is_eval),
        .hit_i     (a_hit),
        .reached_o (a_reached)
    );

    persist_cnt #(.PERSIST(PERSIST)) u_fan_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!en),
        .set_i     (1'b0),
        .step_i    (is_eval),
        .hit_i     (f_hit),
        .reached_o (f_reached)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sample_d   = sample_q;
        alarm_th_d = alarm_th_q;
        fan_th_d   = fan_th_q;
        hyst_d     = hyst_q;
        alarm_d    = alarm_q;
        fan_d      = fan_q;
        on_cnt_d   = on_cnt_q;
        smp_req_d  = smp_req_q;
        cfg_err_d  = 1'b0;
`ifdef SMP_TIMEOUT_EN
        tmo_d      = tmo_q;
        smp_err_d  = smp_err_q;
`endif

        // Writes that would leave fan_th below alarm_th are refused.
        if (cfg_we) begin
            case (cfg_sel)
                CFG_ALARM_TH: begin
                    if (cfg_data > fan_th_q) cfg_err_d = 1'b1;
                    else                     alarm_th_d = cfg_data;
                end
                CFG_FAN_TH: begin
                    if (cfg_data < alarm_th_q) cfg_err_d = 1'b1;
                    else                       fan_th_d = cfg_data;
                end
                CFG_HYST: hyst_d    = cfg_data;
                default:  cfg_err_d = 1'b1;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_WAIT;
                    timer_d = RELOAD;
                end
            end
            ST_WAIT: begin
                if (timer_q == '0) begin
                    state_d   = ST_REQ;
                    smp_req_d = 1'b1;
`ifdef SMP_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_REQ: begin
                if (smp_ack) begin
                    sample_d  = smp_data;
                    smp_req_d = 1'b0;
                    state_d   = ST_EVAL;
`ifdef SMP_TIMEOUT_EN
                    smp_err_d = 1'b0;
                end else if (tmo_hit) begin
                    // Fail-safe: a silent sensor is treated as an over-temperature.
                    smp_req_d = 1'b0;
                    state_d   = ST_WAIT;
                    timer_d   = RELOAD;
                    alarm_d   = 1'b1;
                    smp_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
`endif
                end
            end
            default: begin
                if (a_reached) begin
                    alarm_d = 1'b1;
                end else if (sample_q < alarm_lo && !fan_q) begin
                    alarm_d = 1'b0;
                end
                on_cnt_d = on_next;
                if (f_reached) begin
                    fan_d = 1'b1;
                end else if (fan_q && sample_q < fan_lo && on_next >= 4'(FAN_MIN_ON)) begin
                    fan_d    = 1'b0;
                    on_cnt_d = '0;
                end
                timer_d = RELOAD;
                state_d = ST_WAIT;
            end
        endcase

        if (!en) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            smp_req_d = 1'b0;
            alarm_d   = 1'b0;
            fan_d     = 1'b0;
            on_cnt_d  = '0;
`ifdef SMP_TIMEOUT_EN
            tmo_d     = '0;
            smp_err_d = 1'b0;
`endif
        end

        if (state_d == ST_IDLE) estado_d = EST_OFF;
        else if (!alarm_d)      estado_d = EST_MON;
        else if (fan_d)         estado_d = EST_ALARM_FAN;
        else                    estado_d = EST_ALARM;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            sample_q   <= '0;
            alarm_th_q <= DATA_W'(ALARM_TH_DEF);
            fan_th_q   <= DATA_W'(FAN_TH_DEF);
            hyst_q     <= DATA_W'(HYST_DEF);
            alarm_q    <= 1'b0;
            fan_q      <= 1'b0;
            on_cnt_q   <= '0;
            smp_req_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            estado_q   <= EST_OFF;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sample_q   <= sample_d;
            alarm_th_q <= alarm_th_d;
            fan_th_q   <= fan_th_d;
            hyst_q     <= hyst_d;
            alarm_q    <= alarm_d;
            fan_q      <= fan_d;
            on_cnt_q   <= on_cnt_d;
            smp_req_q  <= smp_req_d;
            cfg_err_q  <= cfg_err_d;
            estado_q   <= estado_d;
        end
    end

`ifdef SMP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q     <= '0;
            smp_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            smp_err_q <= smp_err_d;
        end
    end

    assign smp_err = smp_err_q;
`endif

    assign smp_req       = smp_req_q;
    assign en_alarma     = alarm_q;
    assign en_ventilador = fan_q;
    assign estado        = estado_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_climate_seq.sv
// Bench for climate_seq: directed scenarios plus randomized samples against a rule-level model.
module tb_climate_seq;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SAMPLE_DIV = 4;
    localparam int unsigned PERSIST    = 3;
    localparam int unsigned FAN_MIN_ON = 4;
    localparam int unsigned TIMEOUT    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_sel = 2'd0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic              smp_ack = 1'b0;
    logic [DATA_W-1:0] smp_data = '0;
    logic              smp_req, en_alarma, en_ventilador, cfg_err;
    logic [1:0]        estado;
`ifdef SMP_TIMEOUT_EN
    logic              smp_err;
`endif

    climate_seq #(
        .DATA_W     (DATA_W),
        .SAMPLE_DIV (SAMPLE_DIV),
        .PERSIST    (PERSIST),
        .FAN_MIN_ON (FAN_MIN_ON),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .smp_req       (smp_req),
        .smp_ack       (smp_ack),
        .smp_data      (smp_data),
        .en_alarma     (en_alarma),
        .en_ventilador (en_ventilador),
        .estado        (estado),
        .cfg_err       (cfg_err)
`ifdef SMP_TIMEOUT_EN
        ,
        .smp_err       (smp_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers.
    int m_ath = 30, m_fth = 35, m_hyst = 2;
    int m_acnt = 0, m_fcnt = 0, m_on = 0;
    bit m_alarm = 0, m_fan = 0, m_en = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_estado();
        if (!m_en) return 0;
        if (!m_alarm) return 1;
        return m_fan ? 3 : 2;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_alarm"}, en_alarma, m_alarm);
        check({tag, "_fan"}, en_ventilador, m_fan);
        check({tag, "_estado"}, estado, m_estado());
    endtask

    task automatic model_clear();
        m_acnt = 0; m_fcnt = 0; m_on = 0; m_alarm = 0; m_fan = 0;
    endtask

    task automatic model_eval(input int s);
        int alo, flo;
        bit a_old, f_old;
        alo   = (m_ath > m_hyst) ? m_ath - m_hyst : 0;
        flo   = (m_fth > m_hyst) ? m_fth - m_hyst : 0;
        a_old = m_alarm;
        f_old = m_fan;
        if (s >= m_ath) begin
            m_acnt = (m_acnt + 1 > PERSIST) ? PERSIST : m_acnt + 1;
            if (m_acnt == PERSIST) m_alarm = 1;
        end else begin
            m_acnt = 0;
            if (s < alo && !f_old) m_alarm = 0;
        end
        if (a_old && s >= m_fth) begin
            m_fcnt = (m_fcnt + 1 > PERSIST) ? PERSIST : m_fcnt + 1;
            if (m_fcnt == PERSIST) m_fan = 1;
        end else begin
            m_fcnt = 0;
        end
        if (f_old) m_on = (m_on < 15) ? m_on + 1 : 15;
        if (f_old && s < flo && m_on >= FAN_MIN_ON) begin
            m_fan = 0;
            m_on  = 0;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (smp_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", smp_req, 1);
    endtask

    task automatic ack_sample(input int v, input int dly);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("req_held", smp_req, 1);
        end
        smp_ack  = 1'b1;
        smp_data = DATA_W'(v);
        tick();
        smp_ack  = 1'b0;
        smp_data = DATA_W'($urandom);
        check("req_drop", smp_req, 0);
        check_outputs("pre_eval");
        model_eval(v);
        tick();
        check_outputs("post_eval");
    endtask

    task automatic sample(input int v);
        wait_req();
        ack_sample(v, $urandom_range(0, 2));
    endtask

    task automatic cfg_write(input int sel, input int data);
        bit rej;
        rej = (sel == 3) || (sel == 0 && data > m_fth) || (sel == 1 && data < m_ath);
        if (!rej) begin
            if (sel == 0) m_ath = data;
            else if (sel == 1) m_fth = data;
            else m_hyst = data;
        end
        cfg_we   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_data = DATA_W'(data);
        tick();
        cfg_we = 1'b0;
        check("cfg_err", cfg_err, rej);
        tick();
        check("cfg_err_pulse", cfg_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_req", smp_req, 0);
        check("rst_cfg_err", cfg_err, 0);
        check_outputs("rst");

        // First request arrives SAMPLE_DIV cycles after entering WAIT.
        rst  = 1'b1;
        en   = 1'b1;
        m_en = 1;
        tick();
        check("wait_estado", estado, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_no_req", smp_req, 0);
        end
        tick();
        check("req_rise", smp_req, 1);
        ack_sample(20, 0);

        // 31,29,31 must not raise the alarm; two more 31s do.
        sample(31);
        sample(29);
        sample(31);
        check("no_alarm_band", en_alarma, 0);
        sample(31);
        sample(31);
        check("alarm_set", en_alarma, 1);
        check("alarm_estado", estado, 2);

        for (int i = 0; i < 3; i++) sample(36);
        check("fan_set", en_ventilador, 1);
        check("fan_estado", estado, 3);
        for (int i = 0; i < 3; i++) sample(20);
        check("fan_min_on", en_ventilador, 1);
        sample(20);
        check("fan_off", en_ventilador, 0);
        check("alarm_kept", en_alarma, 1);
        sample(20);
        check("alarm_clear", en_alarma, 0);

        cfg_write(1, 25);
        cfg_write(3, 40);
        cfg_write(2, 3);
        cfg_write(2, 2);

        // Abort a handshake with the alarm on; the late ack must be ignored.
        for (int i = 0; i < 3; i++) sample(33);
        check("pre_abort_alarm", en_alarma, 1);
        wait_req();
        en   = 1'b0;
        m_en = 0;
        model_clear();
        tick();
        check("abort_req", smp_req, 0);
        check_outputs("abort");
        smp_ack  = 1'b1;
        smp_data = 8'd44;
        tick();
        smp_ack = 1'b0;
        check("late_ack_req", smp_req, 0);
        check_outputs("late_ack");
        tick();
        en   = 1'b1;
        m_en = 1;
        tick();
        check("reenable_estado", estado, 1);
        for (int i = 0; i < 3; i++) sample(30);
        check("th_retained_alarm", en_alarma, 1);
        sample(36);
        sample(36);
        sample(35);
        check("th_retained_fan", en_ventilador, 1);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                int sel;
                sel = $urandom_range(0, 3);
                cfg_write(sel, (sel == 2) ? $urandom_range(0, 6) : $urandom_range(20, 45));
            end
            sample($urandom_range(15, 45));
        end

`ifdef SMP_TIMEOUT_EN
        wait_req();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            check("tmo_req_held", smp_req, 1);
        end
        tick();
        m_alarm = 1;
        m_acnt  = PERSIST;
        check("tmo_req_drop", smp_req, 0);
        check("tmo_smp_err", smp_err, 1);
        check_outputs("tmo");
        sample(m_ath);
        check("tmo_err_cleared", smp_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
